// File: rtl/key_set_ctrl_if.sv
// Key-pulse / display bundle between the debouncer, the setting controller and
// the seven-segment stage. The controller takes the slave side.
interface key_set_ctrl_if;
  logic       key1_en;
  logic       key2_en;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [1:0] mode;
  logic       blink;
  logic       val_upd;

  modport master (
    output key1_en, key2_en,
    input  tens, ones, mode, blink, val_upd
  );

  modport slave (
    input  key1_en, key2_en,
    output tens, ones, mode, blink, val_upd
  );
endinterface

// File: rtl/key_set_ctrl.sv
// Two-key, two-digit BCD setting controller: key1 walks RUN -> SET_TENS ->
// SET_ONES -> RUN (commit), key2 increments; idle timeout and blink are internal.
module key_set_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 250_000_000,
  parameter int unsigned BLINK_HALF  = 12_500_000
) (
  input  logic           clk,
  input  logic           rst,
  key_set_ctrl_if.slave  bus
);

  localparam logic [27:0] IDLE_LAST  = 28'(TIMEOUT_CYC - 1);
  localparam logic [23:0] BLINK_LAST = 24'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_TENS = 2'd1,
    SET_ONES = 2'd2
  } mode_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  function automatic logic [3:0] digit_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  mode_e       mode_q,    mode_d;
  bcd2_t       value_q,   value_d;
  bcd2_t       shadow_q,  shadow_d;
  bcd2_t       disp_q,    disp_d;
  logic [27:0] idle_q,    idle_d;
  logic [23:0] bcnt_q,    bcnt_d;
  logic        blink_q,   blink_d;
  logic        val_upd_q, val_upd_d;

  logic key1, key2, key_any, timeout;

  assign key1    = bus.key1_en;
  assign key2    = bus.key2_en;
  assign key_any = key1 | key2;
  assign timeout = (idle_q == IDLE_LAST);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    mode_d    = mode_q;
    value_d   = value_q;
    shadow_d  = shadow_q;
    val_upd_d = 1'b0;

    unique case (mode_q)
      RUN: begin
        if (key1) begin
          shadow_d = value_q;
          mode_d   = SET_TENS;
        end else if (key2) begin
          if (value_q.ones == 4'd9) begin
            value_d.ones = 4'd0;
            value_d.tens = digit_inc(value_q.tens);
          end else begin
            value_d.ones = value_q.ones + 4'd1;
          end
        end
      end
      SET_TENS: begin
        if (key1)         mode_d        = SET_ONES;
        else if (key2)    shadow_d.tens = digit_inc(shadow_q.tens);
        else if (timeout) mode_d        = RUN;
      end
      SET_ONES: begin
        if (key1) begin
          value_d   = shadow_q;
          val_upd_d = 1'b1;
          mode_d    = RUN;
        end else if (key2) begin
          shadow_d.ones = digit_inc(shadow_q.ones);
        end else if (timeout) begin
          mode_d = RUN;
        end
      end
      default: mode_d = RUN;
    endcase

    // Entering a SET state is always caused by a key pulse, so one clear covers both.
    if (mode_d == RUN || key_any) begin
      idle_d  = '0;
      bcnt_d  = '0;
      blink_d = 1'b0;
    end else begin
      idle_d = idle_q + 28'd1;
      if (bcnt_q == BLINK_LAST) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d  = bcnt_q + 24'd1;
        blink_d = blink_q;
      end
    end

    disp_d = (mode_d == RUN) ? value_d : shadow_d;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= RUN;
      value_q   <= '0;
      shadow_q  <= '0;
      disp_q    <= '0;
      idle_q    <= '0;
      bcnt_q    <= '0;
      blink_q   <= 1'b0;
      val_upd_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      value_q   <= value_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      idle_q    <= idle_d;
      bcnt_q    <= bcnt_d;
      blink_q   <= blink_d;
      val_upd_q <= val_upd_d;
    end
  end

  assign bus.tens    = disp_q.tens;
  assign bus.ones    = disp_q.ones;
  assign bus.mode    = mode_q;
  assign bus.blink   = blink_q;
  assign bus.val_upd = val_upd_q;

endmodule

// File: tb/tb_key_set_ctrl.sv
// Scoreboard bench for key_set_ctrl with short timeout/blink periods; a
// behavioural model pushes expected outputs per driven cycle.
module tb_key_set_ctrl;

  localparam int unsigned TO = 20;
  localparam int unsigned BH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  key_set_ctrl_if bus();

  key_set_ctrl #(.TIMEOUT_CYC(TO), .BLINK_HALF(BH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode;
    int tens;
    int ones;
    int blink;
    int upd;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  int m_mode, m_vt, m_vo, m_st, m_so, m_idle, m_bcnt, m_blink, m_upd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_vt = 0; m_vo = 0; m_st = 0; m_so = 0;
    m_idle = 0; m_bcnt = 0; m_blink = 0; m_upd = 0;
  endtask

  function automatic int inc9(input int d);
    return (d == 9) ? 0 : d + 1;
  endfunction

  task automatic model_edge(input logic k1, input logic k2);
    bit tmo;
    tmo   = (m_idle == TO - 1);
    m_upd = 0;
    case (m_mode)
      0: if (k1) begin m_st = m_vt; m_so = m_vo; m_mode = 1; end
         else if (k2) begin
           if (m_vo == 9) begin m_vo = 0; m_vt = inc9(m_vt); end
           else m_vo = m_vo + 1;
         end
      1: if (k1) m_mode = 2;
         else if (k2) m_st = inc9(m_st);
         else if (tmo) m_mode = 0;
      default: if (k1) begin m_vt = m_st; m_vo = m_so; m_upd = 1; m_mode = 0; end
         else if (k2) m_so = inc9(m_so);
         else if (tmo) m_mode = 0;
    endcase
    if (m_mode == 0 || k1 || k2) begin
      m_idle = 0; m_bcnt = 0; m_blink = 0;
    end else begin
      m_idle++;
      if (m_bcnt == BH - 1) begin m_bcnt = 0; m_blink = 1 - m_blink; end
      else m_bcnt++;
    end
  endtask

  task automatic step(input logic k1, input logic k2);
    exp_t e;
    bus.key1_en = k1;
    bus.key2_en = k2;
    model_edge(k1, k2);
    e.mode  = m_mode;
    e.tens  = (m_mode == 0) ? m_vt : m_st;
    e.ones  = (m_mode == 0) ? m_vo : m_so;
    e.blink = m_blink;
    e.upd   = m_upd;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.key1_en = 1'b0;
    bus.key2_en = 1'b0;
    e = exp_q.pop_front();
    check("mode",    32'(bus.mode),    32'(e.mode));
    check("tens",    32'(bus.tens),    32'(e.tens));
    check("ones",    32'(bus.ones),    32'(e.ones));
    check("blink",   32'(bus.blink),   32'(e.blink));
    check("val_upd", 32'(bus.val_upd), 32'(e.upd));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mode"},  32'(bus.mode),    0);
    check({tag, "_tens"},  32'(bus.tens),    0);
    check({tag, "_ones"},  32'(bus.ones),    0);
    check({tag, "_blink"}, 32'(bus.blink),   0);
    check({tag, "_upd"},   32'(bus.val_upd), 0);
  endtask

  initial begin
    int n;
    bus.key1_en = 1'b0;
    bus.key2_en = 1'b0;
    model_reset();
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // RUN increment and 99 -> 00 wrap
    repeat (12) step(1'b0, 1'b1);
    check("run12_tens", 32'(bus.tens), 1);
    check("run12_ones", 32'(bus.ones), 2);
    repeat (88) step(1'b0, 1'b1);
    check("run100_tens", 32'(bus.tens), 0);
    check("run100_ones", 32'(bus.ones), 0);

    // Full edit to 31
    step(1'b1, 1'b0);
    repeat (3)  step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    repeat (11) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    check("commit_upd",  32'(bus.val_upd), 1);
    check("commit_tens", 32'(bus.tens), 3);
    check("commit_ones", 32'(bus.ones), 1);
    step(1'b0, 1'b0);

    // Timeout: value 45, shadow 55, back to RUN 20 edges after last key2
    repeat (14) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("to_shadow_tens", 32'(bus.tens), 5);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 1'b0);
      if (bus.mode == 2'd0) begin n = i; break; end
    end
    check("to_edges", 32'(n), TO);
    check("to_tens", 32'(bus.tens), 4);
    check("to_ones", 32'(bus.ones), 5);

    // Blink phase, restart on key2, then timeout into RUN
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    check("blink_pre", 32'(bus.blink), 0);
    step(1'b0, 1'b0);
    check("blink_first", 32'(bus.blink), 1);
    repeat (6) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("blink_key_clr", 32'(bus.blink), 0);
    repeat (25) step(1'b0, 1'b0);
    repeat (5)  step(1'b0, 1'b0);

    // Simultaneous keys in SET_TENS with shadow tens = 2
    step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b1);
    check("sim_pre_tens", 32'(bus.tens), 2);
    step(1'b1, 1'b1);
    check("sim_mode", 32'(bus.mode), 2);
    check("sim_tens", 32'(bus.tens), 2);

    // Commit 25, then build value 10 and shadow 78 in SET_ONES
    step(1'b1, 1'b0);
    repeat (85) step(1'b0, 1'b1);
    check("pre_rst_value_tens", 32'(bus.tens), 1);
    step(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b1);
    check("pre_rst_ones", 32'(bus.ones), 8);

    // Asynchronous reset mid-edit
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    step(1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_set_ctrl.md
# key_set_ctrl

Two-key, two-digit BCD setting controller. It sits directly downstream of the dual-key debouncer and consumes its single-cycle press pulses: key 1 steps through the edit modes, and key 2 increments the selected digit. The committed value and the edit state drive the seven-segment display stage. Blink and inactivity-timeout timing are generated internally.

## Interface
- TIMEOUT_CYC, 250_000_000: idle cycles in an edit mode before abandoning the edit (5 s at 50 MHz); counter width 28 bits; legal range 2..2^28-1.
- BLINK_HALF, 12_500_000: half-period of the edit blink, in cycles (0.25 s at 50 MHz); legal range 2..2^24-1.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- key1_en  input  1  one-cycle press pulse from the debouncer; mode/select key.
- key2_en  input  1  one-cycle press pulse from the debouncer; increment key.
- tens  output  4  displayed tens digit, BCD 0..9.
- ones  output  4  displayed ones digit, BCD 0..9.
- mode  output  2  0 = RUN, 1 = SET_TENS, 2 = SET_ONES; 3 is never driven.
- blink  output  1  1 = the selected digit is blanked this phase; always 0 in RUN.
- val_upd  output  1  one-cycle pulse when an edit is committed.

## Operation
- Registers:
  - value: 2 BCD digits holding the committed value.
  - shadow: 2 BCD digits holding the edit copy.
  - mode: the state machine state.
  - idle counter: 28 bits.
  - blink counter: 24 bits, plus the blink flag.
- Output mux: tens/ones show value in RUN and shadow in SET_TENS/SET_ONES.
- RUN state:
  - key1_en: shadow <= value; go to SET_TENS.
  - key2_en alone: value increments by 1 as a decimal pair with carry. 09 -> 10, 99 -> 00 (wrap, no flag).
- SET_TENS state:
  - key2_en: shadow tens <= (tens == 9) ? 0 : tens + 1. No carry into or out of ones.
  - key1_en: go to SET_ONES.
- SET_ONES state:
  - key2_en: shadow ones <= (ones == 9) ? 0 : ones + 1. No carry into tens.
  - key1_en: value <= shadow; val_upd = 1 for exactly one cycle; go to RUN.
- Simultaneous key1_en and key2_en in the same cycle: key1_en is acted on; key2_en is discarded in every state.
- Idle timeout (SET states only):
  - The idle counter clears on entry to a SET state and on any key pulse (key1_en or key2_en).
  - Otherwise it increments every cycle.
  - When it reaches TIMEOUT_CYC-1 with no pulse that cycle, the next state is RUN. value is unchanged, shadow is discarded, and val_upd stays 0.
  - In RUN the counter is held at 0.
- Blink:
  - The blink counter and blink flag clear to 0 on entry to a SET state and on any key pulse.
  - Otherwise, in a SET state, the counter runs 0..BLINK_HALF-1; blink toggles at each wrap.
  - In RUN, blink and the counter are forced to 0.

## Timing
- Reset (asynchronous, takes effect immediately) gives:
  - mode = 0, value = 00, shadow = 00.
  - tens = 0, ones = 0, blink = 0, val_upd = 0.
  - Both counters = 0.
- Reset asserted mid-edit discards the edit and produces no val_upd.
- All outputs are registered. A pulse sampled at edge k produces its effect on mode/tens/ones/val_upd after edge k (latency 1 cycle). val_upd is high for the cycle following edge k only.
- Timeout:
  - With the last key pulse sampled at edge k, mode returns to 0 after edge k+TIMEOUT_CYC.
  - A key pulse sampled at that same edge wins: it is processed normally and the counter clears.
- Blink: the first toggle occurs BLINK_HALF edges after entry to a SET state or after the last key pulse; subsequent toggles follow every BLINK_HALF edges.
- Back-to-back pulses on consecutive cycles are each processed; there is no minimum spacing.
- The inputs are assumed to be single-cycle pulses. A held-high input is treated as one press per cycle.

## Test plan
- Reset then RUN increment: rst pulse, then 12 key2_en pulses -> tens/ones = 1/2, mode = 0; continue to 100 pulses total -> value = 00 (wrap at 99 -> 00).
- Full edit: value 00; key1, key2 x3, key1, key2 x11, key1 -> mode sequence 1, 2, 0; committed value = 31 (ones wrap 9 -> 0 -> 1); val_upd high for exactly 1 cycle after the third key1 edge.
- Timeout (TIMEOUT_CYC = 20): value 45; key1, key2 -> shadow 55 shown; no further keys -> mode = 0 exactly 20 edges after the key2 edge; display returns to 45; val_upd never asserted.
- Blink (BLINK_HALF = 4): enter SET_TENS -> blink = 0 for 4 cycles, then toggles every 4 cycles; key2 pulse -> blink forced to 0 and the phase restarts; in RUN blink = 0 throughout.
- Simultaneous keys: in SET_TENS with shadow 2x, key1_en and key2_en high in the same cycle -> mode = 2, shadow tens still 2.
- Reset mid-edit: in SET_ONES with shadow 78 and value 10, assert rst -> all outputs 0 immediately (async, before the next edge); after release, mode = 0, tens/ones = 0/0, no val_upd.
